// File: rtl/vout_scale_up.sv
// rtl/vout_scale_up.sv - display raster regeneration with nearest-neighbour upscale from a line-fetch FIFO
module vout_scale_up #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int MAX_SRC_W = 2048
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [11:0] s_width,
  input  logic [11:0] s_height,
  input  logic [15:0] h_scale_k,
  input  logic [15:0] v_scale_k,
  input  logic        fifo_rdempty,
  output logic        fifo_rden,
  input  logic [7:0]  fifo_data,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [7:0]  pixel_data_out,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(MAX_SRC_W);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] v_next;
  logic [19:0]   h_acc;
  logic [19:0]   v_acc;
  logic [19:0]   v_acc_nxt;
  logic [15:0]   hk_eff;
  logic [15:0]   vk_eff;
  logic          line_end;
  logic          row_active;
  logic          active;
  logic          next_active;
  logic          hs_raw;
  logic          vs_raw;
  logic          frame_init;
  logic          decide;
  logic          need_swap;
  logic [11:0]   src_y;
  logic [11:0]   src_x;
  logic [11:0]   s_last;
  logic [AW-1:0] rd_addr;

  fetch_state_t  state;
  logic [11:0]   req_cnt;
  logic [11:0]   wr_addr;
  logic          rd_pend;
  logic          wr_en;
  logic [11:0]   fetch_line;
  logic [11:0]   back_line;
  logic [11:0]   front_line;
  logic          front_valid;
  logic          front_sel;
  logic          armed;

  logic [7:0]    buf0 [MAX_SRC_W];
  logic [7:0]    buf1 [MAX_SRC_W];
  logic [7:0]    rd_q0;
  logic [7:0]    rd_q1;

  logic          de_d1;
  logic          hs_d1;
  logic          vs_d1;
  logic          sel_d1;
  logic          valid_d1;

  assign hk_eff = (h_scale_k > 16'h0100) ? 16'h0100 : h_scale_k;
  assign vk_eff = (v_scale_k > 16'h0100) ? 16'h0100 : v_scale_k;

  assign line_end    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_next      = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
  assign row_active  = (int'(v_cnt) < V_ACTIVE);
  assign active      = (int'(h_cnt) < H_ACTIVE) && row_active;
  assign next_active = (int'(v_next) < V_ACTIVE);
  assign hs_raw      = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw      = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
  assign frame_init  = (int'(v_cnt) == V_ACTIVE) && (h_cnt == '0);
  assign frame_start = frame_init;

  // The decision for line n+1 must see the accumulator already stepped past line n.
  assign v_acc_nxt = (line_end && row_active) ? v_acc + {4'b0, vk_eff} : v_acc;
  assign src_y     = v_acc_nxt[19:8];
  assign decide    = armed && line_end && next_active;
  assign need_swap = !front_valid || (src_y != front_line);

  assign src_x   = h_acc[19:8];
  assign s_last  = s_width - 12'd1;
  assign rd_addr = (src_x > s_last) ? s_last[AW-1:0] : src_x[AW-1:0];

  // No read is issued on the frame-init cycle, so the restarted fetch never pops a word it would drop.
  assign fifo_rden = (state == FETCH) && !fifo_rdempty && (req_cnt < s_width) && !frame_init;
  assign wr_en     = rd_pend && (state == FETCH) && !frame_init;

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_acc       <= '0;
      v_acc       <= '0;
      state       <= IDLE;
      req_cnt     <= '0;
      wr_addr     <= '0;
      rd_pend     <= 1'b0;
      fetch_line  <= '0;
      back_line   <= '0;
      front_line  <= '0;
      front_valid <= 1'b0;
      front_sel   <= 1'b0;
      armed       <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + HW'(1);
      if (line_end) begin
        v_cnt <= v_next;
      end
      if (line_end) begin
        h_acc <= '0;
      end else if (active) begin
        h_acc <= h_acc + {4'b0, hk_eff};
      end
      rd_pend <= fifo_rden;

      if (frame_init) begin
        v_acc       <= '0;
        front_valid <= 1'b0;
        fetch_line  <= '0;
        state       <= FETCH;
        req_cnt     <= '0;
        wr_addr     <= '0;
        rd_pend     <= 1'b0;
        // Line decisions are meaningless until the first frame has had its blanking to prefetch.
        armed       <= 1'b1;
      end else begin
        v_acc <= v_acc_nxt;
        if (fifo_rden) begin
          req_cnt <= req_cnt + 12'd1;
        end
        if (wr_en) begin
          wr_addr <= wr_addr + 12'd1;
          if (wr_addr + 12'd1 == s_width) begin
            state     <= DONE;
            back_line <= fetch_line;
          end
        end
        if (decide && need_swap) begin
          if (state == DONE) begin
            front_sel   <= ~front_sel;
            front_valid <= 1'b1;
            front_line  <= back_line;
            if (back_line + 12'd1 < s_height) begin
              state      <= FETCH;
              fetch_line <= back_line + 12'd1;
              req_cnt    <= '0;
              wr_addr    <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            underflow <= 1'b1;
          end
        end
      end
    end
  end

  // front_sel high means buf1 is displayed and buf0 is being filled.
  always_ff @(posedge pixel_clk) begin
    if (wr_en && front_sel) begin
      buf0[wr_addr[AW-1:0]] <= fifo_data;
    end
    if (wr_en && !front_sel) begin
      buf1[wr_addr[AW-1:0]] <= fifo_data;
    end
    rd_q0 <= buf0[rd_addr];
    rd_q1 <= buf1[rd_addr];
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_d1          <= 1'b0;
      hs_d1          <= 1'b0;
      vs_d1          <= 1'b0;
      sel_d1         <= 1'b0;
      valid_d1       <= 1'b0;
      de             <= 1'b0;
      hs             <= 1'b0;
      vs             <= 1'b0;
      pixel_data_out <= 8'd0;
    end else begin
      de_d1          <= active;
      hs_d1          <= hs_raw;
      vs_d1          <= vs_raw;
      sel_d1         <= front_sel;
      valid_d1       <= front_valid;
      de             <= de_d1;
      hs             <= hs_d1;
      vs             <= vs_d1;
      pixel_data_out <= (de_d1 && valid_d1) ? (sel_d1 ? rd_q1 : rd_q0) : 8'd0;
    end
  end

endmodule

// File: tb/tb_vout_scale_up.sv
// tb/tb_vout_scale_up.sv - table-driven scoreboard bench for vout_scale_up
module tb_vout_scale_up;

  localparam int H_ACTIVE  = 8;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 3;
  localparam int H_BP      = 9;
  localparam int V_ACTIVE  = 4;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 1;
  localparam int MAX_SRC_W = 16;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME     = H_TOTAL * V_TOTAL;
  localparam int S_HS = 0, S_VS = 1, S_FS = 2, S_DE = 3;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] s_width   = 12'd8;
  logic [11:0] s_height  = 12'd4;
  logic [15:0] h_scale_k = 16'h0100;
  logic [15:0] v_scale_k = 16'h0100;
  logic        fifo_rdempty;
  logic        fifo_rden;
  logic [7:0]  fifo_data = 8'd0;
  logic        hs, vs, de;
  logic [7:0]  pixel_data_out;
  logic        frame_start;
  logic        underflow;

  always #5 pixel_clk = ~pixel_clk;

  vout_scale_up #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .MAX_SRC_W(MAX_SRC_W)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst_n(sys_rst_n),
    .s_width(s_width),
    .s_height(s_height),
    .h_scale_k(h_scale_k),
    .v_scale_k(v_scale_k),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rden(fifo_rden),
    .fifo_data(fifo_data),
    .hs(hs),
    .vs(vs),
    .de(de),
    .pixel_data_out(pixel_data_out),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  typedef struct {
    string name;
    int    sw, sh, hk, vk, base, step;
    bit    stall, empty, exp_uf;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] fifo_q [$];
  int         exp_q  [$];
  int         fifo_cnt = 0;
  logic       stall_en = 1'b0;
  logic       stall_ph = 1'b0;
  bit         chk_en   = 1'b0;
  int         rden_cnt = 0;
  int         pix_idx  = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  assign fifo_rdempty = (fifo_cnt == 0) || (stall_en && stall_ph);

  always @(posedge pixel_clk) begin
    if (fifo_rden && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_cnt <= fifo_q.size();
    stall_ph <= stall_en ? ~stall_ph : 1'b0;
  end

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge pixel_clk) begin
    if (fifo_rden) rden_cnt++;
    if (chk_en && de) begin
      if (exp_q.size() == 0) check("pixel_extra", 1, 0);
      else check($sformatf("pixel[%0d]", pix_idx), int'(pixel_data_out), exp_q.pop_front());
      pix_idx++;
    end
  end

  function automatic logic sig(int s);
    case (s)
      S_HS:    return hs;
      S_VS:    return vs;
      S_FS:    return frame_start;
      S_DE:    return de;
      default: return 1'b0;
    endcase
  endfunction

  // Steps whole cycles (sampled on the falling edge) until the signal reaches lvl.
  task automatic wait_for(int s, logic lvl, int max, string name, output int n);
    n = 0;
    while (sig(s) !== lvl) begin
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      n++;
      if (n >= max) begin
        check({name, "_timeout"}, 0, 1);
        return;
      end
    end
  endtask

  function automatic int exp_pix(vec_t v, int x, int y);
    int hk, vk, sx, sy;
    if (v.empty) return 0;
    hk = (v.hk > 256) ? 256 : v.hk;
    vk = (v.vk > 256) ? 256 : v.vk;
    sx = (x * hk) / 256;
    sy = (y * vk) / 256;
    if (sx > v.sw - 1) sx = v.sw - 1;
    return (v.base + v.step * (sy * v.sw + sx)) % 256;
  endfunction

  task automatic load_cfg(vec_t v);
    s_width   = 12'(v.sw);
    s_height  = 12'(v.sh);
    h_scale_k = 16'(v.hk);
    v_scale_k = 16'(v.vk);
    stall_en  = v.stall;
    fifo_q.delete();
    exp_q.delete();
    if (!v.empty)
      for (int y = 0; y < v.sh; y++)
        for (int x = 0; x < v.sw; x++)
          fifo_q.push_back(8'(v.base + v.step * (y * v.sw + x)));
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++)
        exp_q.push_back(exp_pix(v, x, y));
    rden_cnt = 0;
    pix_idx  = 0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_hs"}, int'(hs), 0);
    check({tag, "_vs"}, int'(vs), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_pix"}, int'(pixel_data_out), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_rden"}, int'(fifo_rden), 0);
    check({tag, "_uf"}, int'(underflow), 0);
  endtask

  task automatic do_reset(vec_t v);
    @(negedge pixel_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    load_cfg(v);
    repeat (2) @(negedge pixel_clk);
    sys_rst_n = 1'b1;
  endtask

  // Checks the first full frame after the first frame_start following reset release.
  task automatic check_frame(vec_t v);
    int n;
    wait_for(S_FS, 1'b1, FRAME + 50, {v.name, "_fs1"}, n);
    chk_en = 1'b1;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    check({v.name, "_fs_width"}, int'(frame_start), 0);
    wait_for(S_FS, 1'b1, FRAME + 10, {v.name, "_fs2"}, n);
    chk_en = 1'b0;
    check({v.name, "_fs_period"}, n + 1, FRAME);
    check({v.name, "_underflow"}, int'(underflow), int'(v.exp_uf));
    check({v.name, "_pixels_left"}, exp_q.size(), 0);
    check({v.name, "_rden_count"}, rden_cnt, v.empty ? 0 : v.sw * v.sh);
  endtask

  initial begin
    int n, n_hi, n_lo;
    vecs[0] = '{"pass_1to1",   8, 4, 'h100, 'h100,   0,  1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"upscale_2x",  4, 2, 'h080, 'h080,  10, 10, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"empty_fifo",  8, 4, 'h100, 'h100,   0,  1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"stall_1to1",  8, 4, 'h100, 'h100,   0,  1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"k_clamp",     4, 4, 'h300, 'h200,   5,  7, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"single_px",   1, 1, 'h040, 'h040, 200,  1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge pixel_clk);
    check_zero("reset");

    for (int i = 0; i < 6; i++) begin
      do_reset(vecs[i]);
      check_frame(vecs[i]);
    end

    wait_for(S_HS, 1'b0, H_TOTAL + 5, "hs_low", n);
    wait_for(S_HS, 1'b1, H_TOTAL + 5, "hs_rise", n);
    wait_for(S_HS, 1'b0, H_TOTAL + 5, "hs_fall", n_hi);
    check("hs_width", n_hi, H_SYNC);
    wait_for(S_HS, 1'b1, H_TOTAL + 5, "hs_rise2", n_lo);
    check("hs_period", n_hi + n_lo, H_TOTAL);
    wait_for(S_VS, 1'b0, FRAME + 5, "vs_low", n);
    wait_for(S_VS, 1'b1, FRAME + 5, "vs_rise", n);
    wait_for(S_VS, 1'b0, FRAME + 5, "vs_fall", n);
    check("vs_width", n, V_SYNC * H_TOTAL);

    // Mid-frame reset: get underflow set, stop during line 2, then restart cleanly.
    do_reset(vecs[2]);
    wait_for(S_FS, 1'b1, FRAME + 50, "mid_fs", n);
    repeat ((V_TOTAL - V_ACTIVE) * H_TOTAL + 2 * H_TOTAL + 5) begin
      @(posedge pixel_clk);
      @(negedge pixel_clk);
    end
    check("mid_uf_before", int'(underflow), 1);
    check("mid_de_before", int'(de), 1);
    sys_rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge pixel_clk);
    load_cfg(vecs[0]);
    @(negedge pixel_clk);
    sys_rst_n = 1'b1;
    wait_for(S_HS, 1'b1, 50, "restart_hs", n);
    check("restart_hs_delay", n, H_ACTIVE + H_FP + 2);
    check_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
